wb_packet_arbiter: RTL and testbench
====================================

Name: wb_packet_arbiter

Overview:
- Merges writeback streams from NUM_REQS execute units (ALU, LSU, FPU, vector unit) onto the single commit writeback port.
- Multi-beat writebacks, such as vector register groups sent lane by lane, are framed by sop/eop. A packet is never interleaved with another requester's beats.
- Arbitration is round-robin at packet boundaries. The output is registered.
- The writeback port has no ready signal, so back-pressure is applied only toward the requesters.

Parameters:
- NUM_REQS, 4, number of requesting units (2..8)
- DATAW, 256, width of one writeback payload (uuid, wis, tmask, PC, rd, data, vector fields), opaque to this block
- PERF_W, 16, width of the saturating stall counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  NUM_REQS  per-requester beat valid
- req_data  in  NUM_REQS*DATAW  per-requester payload; requester i occupies bits [i*DATAW +: DATAW]
- req_sop  in  NUM_REQS  first beat of a packet
- req_eop  in  NUM_REQS  last beat of a packet
- req_ready  out  NUM_REQS  beat accepted this cycle when valid&ready
- wb_valid  out  1  writeback beat valid
- wb_data  out  DATAW  writeback payload
- wb_sop  out  1  forwarded sop
- wb_eop  out  1  forwarded eop
- wb_sel  out  max(1,$clog2(NUM_REQS))  index of the source requester
- proto_err  out  1  sticky framing error flag
- perf_stalls  out  PERF_W  saturating count of cycles with any valid but unaccepted request

Behaviour:
- Reset (reset==0 at a clk edge) clears all state:
  - state=IDLE, rr_ptr=0, lock_idx=0
  - wb_valid=0, wb_data=0, wb_sop=0, wb_eop=0, wb_sel=0
  - proto_err=0, perf_stalls=0
  - req_ready=0 while reset is low.
- A reset mid-packet abandons the packet. No partial beat is emitted afterwards.
- State machine: IDLE / LOCKED.
- Grant is combinational in the current cycle:
  - IDLE: grant = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQS.
  - LOCKED: grant = lock_idx, regardless of other valids.
- req_ready[i] = (i==grant) and (state==LOCKED or some req_valid is set). Ready for a non-granted requester is always 0.
- In LOCKED, req_ready[lock_idx] is 1 even if that requester is not valid.
- Transfer occurs when req_valid[grant] & req_ready[grant].
- Transfer timing: the beat appears on wb_* one cycle after the transfer. wb_valid is 1 for exactly one cycle per transfer. With no transfer, the next cycle has wb_valid=0 and wb_data holds its previous value.
- Throughput is one beat per cycle, with no bubble between back-to-back packets.
- Transitions on a transfer:
  - eop=0 → LOCKED, lock_idx=grant.
  - eop=1 → IDLE, rr_ptr = (grant+1) mod NUM_REQS. This holds for single-beat packets (sop=eop=1) too.
- rr_ptr changes only on an eop transfer.
- In LOCKED, an idle locked requester produces wb_valid=0 bubbles. Others keep stalling; there is no timeout.
- Framing: sop is not required to start arbitration; it is forwarded unchanged.
- proto_err is set and stays 1 until reset when either:
  - a transfer occurs in LOCKED with req_sop=1, or
  - a transfer occurs in IDLE with req_sop=0.
- A framing error does not block the beat; it passes through.
- perf_stalls increments by 1 each cycle in which (req_valid & ~req_ready) != 0. It saturates at 2^PERF_W-1.

Test Plan:
1. Reset then idle: reset=0 for 2 cycles then 1, all req_valid=0 → wb_valid=0, req_ready=0000, perf_stalls=0, proto_err=0.
2. Round-robin fairness: NUM_REQS=4, all four hold single-beat packets (sop=eop=1) continuously → wb_sel sequence 0,1,2,3,0,1…, one beat per cycle, wb_valid=1 from cycle 2 onward.
3. Packet atomicity: req1 sends 4-beat packet (sop on beat 0, eop on beat 3) while req0/req2 are valid → wb_sel=1 for 4 consecutive beats; req_ready[0]=req_ready[2]=0 during that time; next grant goes to req2 (rr_ptr=2).
4. Locked bubble: req3 sends sop/!eop, drops valid 3 cycles, resumes with eop while req0 valid → 3 cycles wb_valid=0, req0 not granted until after req3's eop beat; perf_stalls +=4 or more.
5. Framing error: req0 transfers sop=0 in IDLE → proto_err=1 next cycle, beat still emitted with wb_sop=0; proto_err stays 1 until reset.
6. Reset mid-packet: req2 locked after 2 of 4 beats, reset=0 one cycle → state IDLE, rr_ptr=0; next cycle with req0 and req2 valid grants req0.

Source files
------------

// File: rtl/wb_packet_arbiter.sv
// Writeback packet arbiter: merges per-unit writeback streams onto one commit
// port, round-robin at packet boundaries, never interleaving packet beats.
module wb_packet_arbiter #(
    parameter  int NUM_REQS = 4,
    parameter  int DATAW    = 256,
    parameter  int PERF_W   = 16,
    localparam int SELW     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       req_valid,
    input  logic [NUM_REQS*DATAW-1:0] req_data,
    input  logic [NUM_REQS-1:0]       req_sop,
    input  logic [NUM_REQS-1:0]       req_eop,
    output logic [NUM_REQS-1:0]       req_ready,
    output logic                      wb_valid,
    output logic [DATAW-1:0]          wb_data,
    output logic                      wb_sop,
    output logic                      wb_eop,
    output logic [SELW-1:0]           wb_sel,
    output logic                      proto_err,
    output logic [PERF_W-1:0]         perf_stalls
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e              state_q;
    logic [SELW-1:0]     rr_ptr_q;
    logic [SELW-1:0]     lock_idx_q;
    logic                wb_valid_q;
    logic [DATAW-1:0]    wb_data_q;
    logic                wb_sop_q;
    logic                wb_eop_q;
    logic [SELW-1:0]     wb_sel_q;
    logic                proto_err_q;
    logic [PERF_W-1:0]   perf_q;

    logic [SELW-1:0]     grant;
    logic                found;
    logic [SELW:0]       cand;
    logic                any_valid;
    logic [NUM_REQS-1:0] grant_oh;
    logic                xfer;
    logic                sop_g;
    logic                eop_g;
    logic [DATAW-1:0]    data_g;
    logic [SELW-1:0]     rr_ptr_d;
    logic                frame_err_d;
    logic                stall_d;
    logic [PERF_W-1:0]   perf_d;

    // Rotating priority scan starting at rr_ptr; a held packet overrides it.
    always_comb begin
        grant = rr_ptr_q;
        found = 1'b0;
        cand  = '0;
        if (state_q == LOCKED) begin
            grant = lock_idx_q;
        end else begin
            for (int k = 0; k < NUM_REQS; k++) begin
                cand = {1'b0, rr_ptr_q} + (SELW+1)'(k);
                if (cand >= (SELW+1)'(NUM_REQS)) begin
                    cand = cand - (SELW+1)'(NUM_REQS);
                end
                if (!found && req_valid[cand[SELW-1:0]]) begin
                    grant = cand[SELW-1:0];
                    found = 1'b1;
                end
            end
        end
    end

    assign any_valid = |req_valid;
    assign grant_oh  = NUM_REQS'(1) << grant;

    always_comb begin
        req_ready = '0;
        if (reset && (state_q == LOCKED || any_valid)) begin
            req_ready = grant_oh;
        end
    end

    assign xfer   = req_valid[grant] & req_ready[grant];
    assign sop_g  = req_sop[grant];
    assign eop_g  = req_eop[grant];
    assign data_g = req_data[int'(grant)*DATAW +: DATAW];

    assign rr_ptr_d = (grant == SELW'(NUM_REQS-1)) ? '0 : grant + 1'b1;

    // Locked beats must continue a packet; idle grants must open one.
    assign frame_err_d = xfer & ((state_q == LOCKED) ? sop_g : ~sop_g);

    assign stall_d = |(req_valid & ~req_ready);
    assign perf_d  = (stall_d && perf_q != '1) ? perf_q + 1'b1 : perf_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            lock_idx_q  <= '0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_sop_q    <= 1'b0;
            wb_eop_q    <= 1'b0;
            wb_sel_q    <= '0;
            proto_err_q <= 1'b0;
            perf_q      <= '0;
        end else begin
            wb_valid_q <= xfer;
            perf_q     <= perf_d;
            if (frame_err_d) begin
                proto_err_q <= 1'b1;
            end
            if (xfer) begin
                wb_data_q <= data_g;
                wb_sop_q  <= sop_g;
                wb_eop_q  <= eop_g;
                wb_sel_q  <= grant;
                if (eop_g) begin
                    state_q  <= IDLE;
                    rr_ptr_q <= rr_ptr_d;
                end else begin
                    state_q    <= LOCKED;
                    lock_idx_q <= grant;
                end
            end
        end
    end

    assign wb_valid    = wb_valid_q;
    assign wb_data     = wb_data_q;
    assign wb_sop      = wb_sop_q;
    assign wb_eop      = wb_eop_q;
    assign wb_sel      = wb_sel_q;
    assign proto_err   = proto_err_q;
    assign perf_stalls = perf_q;

endmodule

// File: tb/tb_wb_packet_arbiter.sv
// Bench for wb_packet_arbiter: vector table, directed corner sequences and
// randomized traffic checked against a packet-level reference model.
module tb_wb_packet_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int PW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_sop, req_eop, req_ready;
    logic [N*DW-1:0] req_data;
    logic            wb_valid, wb_sop, wb_eop, proto_err;
    logic [DW-1:0]   wb_data;
    logic [1:0]      wb_sel;
    logic [PW-1:0]   perf_stalls;

    wb_packet_arbiter #(.NUM_REQS(N), .DATAW(DW), .PERF_W(PW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data),
        .req_sop(req_sop), .req_eop(req_eop), .req_ready(req_ready),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_sop(wb_sop),
        .wb_eop(wb_eop), .wb_sel(wb_sel), .proto_err(proto_err),
        .perf_stalls(perf_stalls)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [N-1:0] rdy_s;
    logic [DW-1:0] ld [N];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle; ready sampled mid-cycle, registers sampled after edge.
    task automatic cyc(input logic r, input logic [N-1:0] v, s, e,
                       input logic [7:0] tag);
        reset = r; req_valid = v; req_sop = s; req_eop = e;
        for (int i = 0; i < N; i++) begin
            ld[i] = {16'hC0DE, tag, 8'(i)};
            req_data[i*DW +: DW] = ld[i];
        end
        @(negedge clk);
        rdy_s = req_ready;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic         rst;
        logic [N-1:0] v, s, e, rdy;
        logic         wbv;
        logic [1:0]   sel;
        logic         err;
        logic [PW-1:0] perf;
    } vec_t;

    vec_t tbl [15];

    // Reference model state: packet owner (-1 when none) and rotation pointer.
    int own, rr, m_perf;
    logic m_err, m_wbv, m_sop, m_eop;
    logic [DW-1:0] m_data;
    logic [1:0] m_sel;

    function automatic int mgrant(input logic [N-1:0] v);
        if (own >= 0) return own;
        for (int k = 0; k < N; k++) begin
            if (v[(rr + k) % N]) return (rr + k) % N;
        end
        return rr;
    endfunction

    int unsigned left [N];
    logic pv [N], ps [N], pe [N], first [N];
    logic [DW-1:0] pd [N];

    initial begin
        tbl[0]  = '{0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0};
        tbl[1]  = '{0, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 0, 0, 0, 0};
        tbl[2]  = '{1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0};
        tbl[3]  = '{1, 4'b1111, 4'b1111, 4'b1111, 4'b0001, 1, 0, 0, 1};
        tbl[4]  = '{1, 4'b1111, 4'b1111, 4'b1111, 4'b0010, 1, 1, 0, 2};
        tbl[5]  = '{1, 4'b1111, 4'b1111, 4'b1111, 4'b0100, 1, 2, 0, 3};
        tbl[6]  = '{1, 4'b1111, 4'b1111, 4'b1111, 4'b1000, 1, 3, 0, 4};
        tbl[7]  = '{1, 4'b1111, 4'b1111, 4'b1111, 4'b0001, 1, 0, 0, 5};
        tbl[8]  = '{1, 4'b0111, 4'b0111, 4'b0101, 4'b0010, 1, 1, 0, 6};
        tbl[9]  = '{1, 4'b0111, 4'b0101, 4'b0101, 4'b0010, 1, 1, 0, 7};
        tbl[10] = '{1, 4'b0111, 4'b0101, 4'b0101, 4'b0010, 1, 1, 0, 8};
        tbl[11] = '{1, 4'b0111, 4'b0101, 4'b0111, 4'b0010, 1, 1, 0, 9};
        tbl[12] = '{1, 4'b0101, 4'b0101, 4'b0101, 4'b0100, 1, 2, 0, 10};
        tbl[13] = '{1, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 1, 0, 0, 10};
        tbl[14] = '{1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 10};

        reset = 1'b0; req_valid = '0; req_sop = '0; req_eop = '0;
        req_data = '0;
        @(posedge clk);
        #1;

        for (int r = 0; r < 15; r++) begin
            cyc(tbl[r].rst, tbl[r].v, tbl[r].s, tbl[r].e, 8'(r));
            chk($sformatf("tbl%0d ready", r), rdy_s, tbl[r].rdy);
            chk($sformatf("tbl%0d wb_valid", r), wb_valid, tbl[r].wbv);
            chk($sformatf("tbl%0d proto_err", r), proto_err, tbl[r].err);
            chk($sformatf("tbl%0d perf", r), perf_stalls, tbl[r].perf);
            if (tbl[r].wbv) begin
                chk($sformatf("tbl%0d sel", r), wb_sel, tbl[r].sel);
                chk($sformatf("tbl%0d data", r), wb_data,
                    {16'hC0DE, 8'(r), 6'd0, tbl[r].sel});
                chk($sformatf("tbl%0d sop", r), wb_sop, tbl[r].s[tbl[r].sel]);
                chk($sformatf("tbl%0d eop", r), wb_eop, tbl[r].e[tbl[r].sel]);
            end
        end

        // Locked bubble: req3 opens a packet, goes quiet, then closes it.
        cyc(1, 4'b1000, 4'b1000, 4'b0000, 8'h40);
        chk("lock open ready", rdy_s, 4'b1000);
        chk("lock open sel", wb_sel, 3);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 4'b0001, 4'b0001, 4'b0001, 8'h41);
            chk("bubble ready", rdy_s, 4'b1000);
            chk("bubble wb_valid", wb_valid, 0);
        end
        cyc(1, 4'b1001, 4'b0001, 4'b1001, 8'h42);
        chk("lock close ready", rdy_s, 4'b1000);
        chk("lock close sel", wb_sel, 3);
        chk("lock close eop", wb_eop, 1);
        cyc(1, 4'b0001, 4'b0001, 4'b0001, 8'h43);
        chk("after lock ready", rdy_s, 4'b0001);
        chk("after lock data", wb_data, ld[0]);
        chk("after lock perf", perf_stalls, 14);

        // Framing error in IDLE: beat still passes, flag sticks.
        cyc(1, 4'b0001, 4'b0000, 4'b0001, 8'h50);
        chk("ferr wb_valid", wb_valid, 1);
        chk("ferr wb_sop", wb_sop, 0);
        chk("ferr flag", proto_err, 1);
        cyc(1, 4'b0000, 4'b0000, 4'b0000, 8'h51);
        chk("ferr idle wb_valid", wb_valid, 0);
        chk("ferr hold data", wb_data, {16'hC0DE, 8'h50, 8'h00});
        chk("ferr sticky1", proto_err, 1);
        cyc(1, 4'b0001, 4'b0001, 4'b0001, 8'h52);
        chk("ferr sticky2", proto_err, 1);

        // Reset in the middle of a req2 packet.
        cyc(1, 4'b0100, 4'b0100, 4'b0000, 8'h60);
        chk("mid beat0 sel", wb_sel, 2);
        cyc(1, 4'b0100, 4'b0000, 4'b0000, 8'h61);
        chk("mid beat1 ready", rdy_s, 4'b0100);
        cyc(0, 4'b0101, 4'b0101, 4'b0001, 8'h62);
        chk("rst ready", rdy_s, 4'b0000);
        chk("rst wb_valid", wb_valid, 0);
        chk("rst err", proto_err, 0);
        chk("rst perf", perf_stalls, 0);
        chk("rst data", wb_data, 0);
        cyc(1, 4'b0101, 4'b0101, 4'b0001, 8'h63);
        chk("post rst ready", rdy_s, 4'b0001);
        chk("post rst sel", wb_sel, 0);
        chk("post rst perf", perf_stalls, 1);

        // Stall counter saturation while req0 holds the port.
        cyc(1, 4'b0001, 4'b0001, 4'b0000, 8'h70);
        chk("sat lock ready", rdy_s, 4'b0001);
        for (int i = 0; i < 253; i++) cyc(1, 4'b0010, 4'b0010, 4'b0010, 8'h71);
        chk("sat near", perf_stalls, 254);
        for (int i = 0; i < 47; i++) cyc(1, 4'b0010, 4'b0010, 4'b0010, 8'h72);
        chk("sat top", perf_stalls, 255);
        cyc(1, 4'b0011, 4'b0000, 4'b0011, 8'h73);
        chk("sat release ready", rdy_s, 4'b0001);
        chk("sat hold", perf_stalls, 255);
        chk("sat err", proto_err, 0);

        // Randomized traffic against the reference model.
        own = -1; rr = 0; m_perf = 0; m_err = 0;
        m_wbv = 0; m_sop = 0; m_eop = 0; m_data = '0; m_sel = '0;
        for (int i = 0; i < N; i++) begin
            left[i] = 0; pv[i] = 0; ps[i] = 0; pe[i] = 0;
            first[i] = 0; pd[i] = '0;
        end
        for (int c = 0; c < 4000; c++) begin
            logic r, xf, st;
            logic [N-1:0] v, s, e, er;
            int g;
            r = (c == 0) ? 1'b0 : ($urandom_range(0, 599) != 0);
            for (int i = 0; i < N; i++) begin
                if (!pv[i] && $urandom_range(0, 99) < 55) begin
                    if (left[i] == 0) begin
                        left[i] = $urandom_range(1, 4);
                        first[i] = 1'b1;
                    end
                    pv[i] = 1'b1;
                    pd[i] = $urandom;
                    ps[i] = first[i];
                    if ($urandom_range(0, 299) == 0) ps[i] = ~ps[i];
                    pe[i] = (left[i] == 1);
                end
                v[i] = pv[i]; s[i] = ps[i]; e[i] = pe[i];
                req_data[i*DW +: DW] = pd[i];
            end
            reset = r; req_valid = v; req_sop = s; req_eop = e;
            g  = mgrant(v);
            er = (r && (own >= 0 || v != 0)) ? N'(1) << g : '0;
            xf = v[g] && er[g];
            st = (v & ~er) != 0;
            @(negedge clk);
            chk("rnd ready", req_ready, er);
            @(posedge clk);
            #1;
            if (!r) begin
                own = -1; rr = 0; m_perf = 0; m_err = 0;
                m_wbv = 0; m_sop = 0; m_eop = 0; m_data = '0; m_sel = '0;
                for (int i = 0; i < N; i++) begin
                    left[i] = 0; pv[i] = 0;
                end
            end else begin
                m_wbv = xf;
                if (xf) begin
                    m_data = pd[g]; m_sop = s[g]; m_eop = e[g]; m_sel = 2'(g);
                    if ((own >= 0) == s[g]) m_err = 1'b1;
                    if (e[g]) begin
                        own = -1;
                        rr = (g + 1) % N;
                    end else begin
                        own = g;
                    end
                    pv[g] = 1'b0;
                    left[g] = left[g] - 1;
                    first[g] = 1'b0;
                end
                if (st && m_perf < 255) m_perf++;
            end
            chk("rnd wb_valid", wb_valid, m_wbv);
            chk("rnd wb_data", wb_data, m_data);
            chk("rnd wb_sop", wb_sop, m_sop);
            chk("rnd wb_eop", wb_eop, m_eop);
            chk("rnd wb_sel", wb_sel, m_sel);
            chk("rnd proto_err", proto_err, m_err);
            chk("rnd perf", perf_stalls, 64'(m_perf));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
